// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data requester ports and memory macro port shared by the arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  modport slave (
    input  m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport master (
    output m0_req, m0_addr, m1_req, m1_we, m1_addr, m1_wdata, mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency memory port between fetch and data requesters
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be in 1..4");
  end
  typedef enum logic {IDLE, WAIT} state_t;
  state_t            r_state, w_next;
  logic              r_prio, r_owner, r_store;
  logic [2:0]        r_lat_cnt, w_lat_nxt;
  logic              w_win, w_grant, w_done;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  // arbitration, next state and all outputs; reset low forces every output to 0
  always_comb begin
    w_win     = bus.m1_req & (~bus.m0_req | r_prio);
    w_grant   = reset & (r_state == IDLE) & (bus.m0_req | bus.m1_req);
    w_done    = reset & (r_state == WAIT) & (r_lat_cnt == 3'(MEM_LAT));
    w_next    = w_grant ? WAIT : w_done ? IDLE : r_state;
    w_lat_nxt = w_grant ? 3'd1 : w_done ? 3'd0 : (r_state == WAIT) ? r_lat_cnt + 3'd1 : r_lat_cnt;
    w_addr    = w_grant ? (w_win ? bus.m1_addr : bus.m0_addr) : '0;
    w_wdata   = (w_grant & w_win) ? bus.m1_wdata : '0;
    bus.m0_gnt    = w_grant & ~w_win;
    bus.m1_gnt    = w_grant & w_win;
    bus.mem_en    = w_grant;
    bus.mem_we    = w_grant & w_win & bus.m1_we;
    bus.mem_addr  = w_addr;
    bus.mem_wdata = w_wdata;
    bus.m0_rvalid = w_done & ~r_owner;
    bus.m1_rvalid = w_done & r_owner;
    bus.m0_rdata  = (w_done & ~r_owner) ? bus.mem_rdata : '0;
    bus.m1_rdata  = (w_done & r_owner & ~r_store) ? bus.mem_rdata : '0;
    bus.busy      = reset & (r_state == WAIT);
  end
  // state, latency counter, and per-grant priority/ownership capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_prio    <= 1'b0;
      r_owner   <= 1'b0;
      r_store   <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_lat_cnt <= w_lat_nxt;
      if (w_grant) begin
        r_prio  <= ~w_win;
        r_owner <= w_win;
        r_store <= w_win & bus.m1_we;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grant, latency, routing and reset for MEM_LAT 1, 2 and 4
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int checks;
  int errors;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) i2 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) i1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) i4 ();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u2 (.clk(clk), .reset(reset), .bus(i2));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(i1));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) u4 (.clk(clk), .reset(reset), .bus(i4));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    reset = 1'b0;
    i2.m0_req = 1'b1; i2.m1_req = 1'b1;
    @(negedge clk); #1;
    checks++; if (i2.m0_gnt !== 1'b0) begin errors++; $display("FAIL rst_m0_gnt got %b exp 0", i2.m0_gnt); end
    checks++; if (i2.m1_gnt !== 1'b0) begin errors++; $display("FAIL rst_m1_gnt got %b exp 0", i2.m1_gnt); end
    checks++; if (i2.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b exp 0", i2.mem_en); end
    checks++; if (i2.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", i2.busy); end
    i2.m0_req = 1'b0; i2.m1_req = 1'b0;
    reset = 1'b1;
    @(negedge clk); #1;
    checks++; if (i2.mem_en !== 1'b0) begin errors++; $display("FAIL idle_mem_en got %b exp 0", i2.mem_en); end
    checks++; if (i2.mem_addr !== 32'h0) begin errors++; $display("FAIL idle_mem_addr got %h exp 0", i2.mem_addr); end
  endtask

  task automatic test_m0_load;
    @(negedge clk);
    i2.m0_req = 1'b1; i2.m0_addr = 32'h100; i2.mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (i2.m0_gnt !== 1'b1) begin errors++; $display("FAIL ld_m0_gnt got %b exp 1", i2.m0_gnt); end
    checks++; if (i2.mem_en !== 1'b1) begin errors++; $display("FAIL ld_mem_en got %b exp 1", i2.mem_en); end
    checks++; if (i2.mem_we !== 1'b0) begin errors++; $display("FAIL ld_mem_we got %b exp 0", i2.mem_we); end
    checks++; if (i2.mem_addr !== 32'h100) begin errors++; $display("FAIL ld_mem_addr got %h exp 100", i2.mem_addr); end
    checks++; if (i2.busy !== 1'b0) begin errors++; $display("FAIL ld_busy_t0 got %b exp 0", i2.busy); end
    @(negedge clk);
    i2.m0_req = 1'b0;
    #1;
    checks++; if (i2.busy !== 1'b1) begin errors++; $display("FAIL ld_busy_t1 got %b exp 1", i2.busy); end
    checks++; if (i2.mem_en !== 1'b0) begin errors++; $display("FAIL ld_mem_en_t1 got %b exp 0", i2.mem_en); end
    checks++; if (i2.m0_rvalid !== 1'b0) begin errors++; $display("FAIL ld_rvalid_t1 got %b exp 0", i2.m0_rvalid); end
    @(negedge clk); #1;
    checks++; if (i2.busy !== 1'b1) begin errors++; $display("FAIL ld_busy_t2 got %b exp 1", i2.busy); end
    checks++; if (i2.m0_rvalid !== 1'b1) begin errors++; $display("FAIL ld_rvalid_t2 got %b exp 1", i2.m0_rvalid); end
    checks++; if (i2.m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_rdata got %h exp deadbeef", i2.m0_rdata); end
    checks++; if (i2.m1_rvalid !== 1'b0) begin errors++; $display("FAIL ld_m1_rvalid got %b exp 0", i2.m1_rvalid); end
    checks++; if (i2.m1_rdata !== 32'h0) begin errors++; $display("FAIL ld_m1_rdata got %h exp 0", i2.m1_rdata); end
    @(negedge clk); #1;
    checks++; if (i2.busy !== 1'b0) begin errors++; $display("FAIL ld_busy_t3 got %b exp 0", i2.busy); end
    checks++; if (i2.m0_rvalid !== 1'b0) begin errors++; $display("FAIL ld_rvalid_t3 got %b exp 0", i2.m0_rvalid); end
  endtask

  task automatic test_store;
    @(negedge clk);
    i2.m1_req = 1'b1; i2.m1_we = 1'b1; i2.m1_addr = 32'h40; i2.m1_wdata = 32'h12345678;
    i2.mem_rdata = 32'hAAAA5555;
    #1;
    checks++; if (i2.m1_gnt !== 1'b1) begin errors++; $display("FAIL st_m1_gnt got %b exp 1", i2.m1_gnt); end
    checks++; if (i2.m0_gnt !== 1'b0) begin errors++; $display("FAIL st_m0_gnt got %b exp 0", i2.m0_gnt); end
    checks++; if (i2.mem_we !== 1'b1) begin errors++; $display("FAIL st_mem_we got %b exp 1", i2.mem_we); end
    checks++; if (i2.mem_addr !== 32'h40) begin errors++; $display("FAIL st_mem_addr got %h exp 40", i2.mem_addr); end
    checks++; if (i2.mem_wdata !== 32'h12345678) begin errors++; $display("FAIL st_mem_wdata got %h exp 12345678", i2.mem_wdata); end
    @(negedge clk);
    i2.m1_req = 1'b0; i2.m1_we = 1'b0;
    #1;
    checks++; if (i2.m1_rvalid !== 1'b0) begin errors++; $display("FAIL st_rvalid_t1 got %b exp 0", i2.m1_rvalid); end
    @(negedge clk); #1;
    checks++; if (i2.m1_rvalid !== 1'b1) begin errors++; $display("FAIL st_rvalid_t2 got %b exp 1", i2.m1_rvalid); end
    checks++; if (i2.m1_rdata !== 32'h0) begin errors++; $display("FAIL st_rdata got %h exp 0", i2.m1_rdata); end
    checks++; if (i2.m0_rvalid !== 1'b0) begin errors++; $display("FAIL st_m0_rvalid got %b exp 0", i2.m0_rvalid); end
    @(negedge clk); #1;
  endtask

  task automatic test_m1_during_wait;
    @(negedge clk);
    i2.m0_req = 1'b1; i2.m0_addr = 32'h200;
    #1;
    checks++; if (i2.m0_gnt !== 1'b1) begin errors++; $display("FAIL mw_m0_gnt got %b exp 1", i2.m0_gnt); end
    @(negedge clk);
    i2.m0_req = 1'b0; i2.m1_req = 1'b1; i2.m1_we = 1'b0; i2.m1_addr = 32'h300;
    #1;
    checks++; if (i2.m1_gnt !== 1'b0) begin errors++; $display("FAIL mw_m1_gnt_t1 got %b exp 0", i2.m1_gnt); end
    @(negedge clk); #1;
    checks++; if (i2.m1_gnt !== 1'b0) begin errors++; $display("FAIL mw_m1_gnt_t2 got %b exp 0", i2.m1_gnt); end
    checks++; if (i2.m0_rvalid !== 1'b1) begin errors++; $display("FAIL mw_m0_rvalid got %b exp 1", i2.m0_rvalid); end
    checks++; if (i2.m0_rdata !== 32'hAAAA5555) begin errors++; $display("FAIL mw_m0_rdata got %h exp aaaa5555", i2.m0_rdata); end
    @(negedge clk); #1;
    checks++; if (i2.m1_gnt !== 1'b1) begin errors++; $display("FAIL mw_m1_gnt_t3 got %b exp 1", i2.m1_gnt); end
    checks++; if (i2.mem_addr !== 32'h300) begin errors++; $display("FAIL mw_mem_addr got %h exp 300", i2.mem_addr); end
    @(negedge clk);
    i2.m1_req = 1'b0; i2.mem_rdata = 32'h55;
    #1;
    @(negedge clk); #1;
    checks++; if (i2.m1_rvalid !== 1'b1) begin errors++; $display("FAIL mw_m1_rvalid got %b exp 1", i2.m1_rvalid); end
    checks++; if (i2.m1_rdata !== 32'h55) begin errors++; $display("FAIL mw_m1_rdata got %h exp 55", i2.m1_rdata); end
    checks++; if (i2.m0_rvalid !== 1'b0) begin errors++; $display("FAIL mw_m0_rvalid_t5 got %b exp 0", i2.m0_rvalid); end
    @(negedge clk);
    i2.m0_req = 1'b1; i2.m1_req = 1'b1;
    #1;
    checks++; if (i2.m0_gnt !== 1'b1) begin errors++; $display("FAIL mw_prio_m0_gnt got %b exp 1", i2.m0_gnt); end
    checks++; if (i2.m1_gnt !== 1'b0) begin errors++; $display("FAIL mw_prio_m1_gnt got %b exp 0", i2.m1_gnt); end
    @(negedge clk);
    i2.m0_req = 1'b0; i2.m1_req = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk);
    i2.m0_req = 1'b1; i2.m0_addr = 32'h400;
    #1;
    checks++; if (i2.m0_gnt !== 1'b1) begin errors++; $display("FAIL rw_m0_gnt got %b exp 1", i2.m0_gnt); end
    @(negedge clk);
    i2.m1_req = 1'b1; reset = 1'b0;
    #1;
    checks++; if (i2.busy !== 1'b0) begin errors++; $display("FAIL rw_busy got %b exp 0", i2.busy); end
    checks++; if (i2.m0_gnt !== 1'b0) begin errors++; $display("FAIL rw_m0_gnt_rst got %b exp 0", i2.m0_gnt); end
    checks++; if (i2.m1_gnt !== 1'b0) begin errors++; $display("FAIL rw_m1_gnt_rst got %b exp 0", i2.m1_gnt); end
    checks++; if (i2.mem_en !== 1'b0) begin errors++; $display("FAIL rw_mem_en got %b exp 0", i2.mem_en); end
    checks++; if (i2.mem_addr !== 32'h0) begin errors++; $display("FAIL rw_mem_addr got %h exp 0", i2.mem_addr); end
    @(negedge clk); #1;
    checks++; if (i2.m0_rvalid !== 1'b0) begin errors++; $display("FAIL rw_m0_rvalid got %b exp 0", i2.m0_rvalid); end
  endtask

  task automatic test_alternate;
    logic [31:0] d;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) reset = 1'b1;
      d = 32'h1000 + 32'(c);
      i2.mem_rdata = d;
      #1;
      checks++; if (i2.m0_gnt !== (c % 6 == 0)) begin errors++; $display("FAIL alt_m0_gnt c=%0d got %b exp %b", c, i2.m0_gnt, c % 6 == 0); end
      checks++; if (i2.m1_gnt !== (c % 6 == 3)) begin errors++; $display("FAIL alt_m1_gnt c=%0d got %b exp %b", c, i2.m1_gnt, c % 6 == 3); end
      checks++; if (i2.m0_rvalid !== (c % 6 == 2)) begin errors++; $display("FAIL alt_m0_rvalid c=%0d got %b exp %b", c, i2.m0_rvalid, c % 6 == 2); end
      checks++; if (i2.m1_rvalid !== (c % 6 == 5)) begin errors++; $display("FAIL alt_m1_rvalid c=%0d got %b exp %b", c, i2.m1_rvalid, c % 6 == 5); end
      checks++; if (i2.m0_rdata !== ((c % 6 == 2) ? d : 32'h0)) begin errors++; $display("FAIL alt_m0_rdata c=%0d got %h", c, i2.m0_rdata); end
      checks++; if (i2.m1_rdata !== ((c % 6 == 5) ? d : 32'h0)) begin errors++; $display("FAIL alt_m1_rdata c=%0d got %h", c, i2.m1_rdata); end
    end
    @(negedge clk);
    i2.m0_req = 1'b0; i2.m1_req = 1'b0;
    #1;
    checks++; if (i2.mem_en !== 1'b0) begin errors++; $display("FAIL alt_drop_mem_en got %b exp 0", i2.mem_en); end
  endtask

  task automatic test_back_to_back_lat;
    logic [31:0] d1, d4;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      i1.m0_req = 1'b1; i1.m0_addr = 32'h80;
      i4.m0_req = 1'b1; i4.m0_addr = 32'h90;
      d1 = 32'h2000 + 32'(c);
      d4 = 32'h3000 + 32'(c);
      i1.mem_rdata = d1;
      i4.mem_rdata = d4;
      #1;
      checks++; if (i1.m0_gnt !== (c % 2 == 0)) begin errors++; $display("FAIL l1_gnt c=%0d got %b exp %b", c, i1.m0_gnt, c % 2 == 0); end
      checks++; if (i1.m0_rvalid !== (c % 2 == 1)) begin errors++; $display("FAIL l1_rvalid c=%0d got %b exp %b", c, i1.m0_rvalid, c % 2 == 1); end
      checks++; if (i1.m0_rdata !== ((c % 2 == 1) ? d1 : 32'h0)) begin errors++; $display("FAIL l1_rdata c=%0d got %h", c, i1.m0_rdata); end
      checks++; if (i4.m0_gnt !== (c % 5 == 0)) begin errors++; $display("FAIL l4_gnt c=%0d got %b exp %b", c, i4.m0_gnt, c % 5 == 0); end
      checks++; if (i4.m0_rvalid !== (c % 5 == 4)) begin errors++; $display("FAIL l4_rvalid c=%0d got %b exp %b", c, i4.m0_rvalid, c % 5 == 4); end
      checks++; if (i4.m0_rdata !== ((c % 5 == 4) ? d4 : 32'h0)) begin errors++; $display("FAIL l4_rdata c=%0d got %h", c, i4.m0_rdata); end
      checks++; if (i4.busy !== (c % 5 != 0)) begin errors++; $display("FAIL l4_busy c=%0d got %b exp %b", c, i4.busy, c % 5 != 0); end
    end
    @(negedge clk);
    i1.m0_req = 1'b0; i4.m0_req = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    i2.m0_req = 1'b0; i2.m0_addr = '0; i2.m1_req = 1'b0; i2.m1_we = 1'b0; i2.m1_addr = '0; i2.m1_wdata = '0; i2.mem_rdata = '0;
    i1.m0_req = 1'b0; i1.m0_addr = '0; i1.m1_req = 1'b0; i1.m1_we = 1'b0; i1.m1_addr = '0; i1.m1_wdata = '0; i1.mem_rdata = '0;
    i4.m0_req = 1'b0; i4.m0_addr = '0; i4.m1_req = 1'b0; i4.m1_we = 1'b0; i4.m1_addr = '0; i4.m1_wdata = '0; i4.mem_rdata = '0;
    test_reset();
    test_m0_load();
    test_store();
    test_m1_during_wait();
    test_reset_mid_wait();
    test_alternate();
    test_back_to_back_lat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
